// File: rtl/stats_arbiter_avlstrm_pkg.sv
// Shared stats word format and register-map constants used by the stats
// packers, the arbiter and the unpacker.
package stats_arbiter_avlstrm_pkg;

  localparam int ADDR_W = 8;
  localparam int VAL_W  = 32;

  // Address 0 is reserved as "no register"; the map holds NUM_REG entries.
  localparam logic [ADDR_W-1:0] REG_NOTUSED    = 8'd0;
  localparam logic [ADDR_W-1:0] NUM_REG        = 8'd16;
  localparam int unsigned       STATS_INTERVAL = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [VAL_W-1:0]  val;
  } stats_t;

  function automatic logic stats_fwd(input logic [ADDR_W-1:0] addr);
    return (addr != REG_NOTUSED) && (addr < NUM_REG);
  endfunction

endpackage

// File: rtl/avl_stream_if.sv
// Single-beat Avalon-ST style channel carrying one stats_t per transfer.
interface avl_stream_if;
  import stats_arbiter_avlstrm_pkg::*;

  logic   valid;
  logic   ready;
  logic   sop;
  logic   eop;
  stats_t data;

  modport tx (output valid, sop, eop, data, input ready);
  modport rx (input valid, data, output ready);
endinterface

// File: rtl/stats_rr_arb.sv
// Round-robin one-hot grant, combinational from req; rr_ptr moves past the
// winner only on cycles where the grant is actually taken (advance).
module stats_rr_arb #(
  parameter int NUM_SRC = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [NUM_SRC-1:0] grant
);
  localparam int PW = $clog2(NUM_SRC);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    win   = rr_ptr;
    idx   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        found      = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Explicit wrap keeps non-power-of-two NUM_SRC inside 0..NUM_SRC-1.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (win == PW'(NUM_SRC - 1)) ? '0 : win + PW'(1);
    end
  end
endmodule

// File: rtl/stats_arbiter_avlstrm.sv
// Merges NUM_SRC stats streams into one; 1-cycle latency through a one-entry
// output register, inputs stalled while that register is full and not drained.
module stats_arbiter_avlstrm
  import stats_arbiter_avlstrm_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  avl_stream_if.rx    stats_in [NUM_SRC],
  avl_stream_if.tx    stats_out,
  output logic [31:0] drop_cnt
);
  localparam int SW = $bits(stats_t);

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] rdy;
  stats_t             src_data [NUM_SRC];
  logic [SW-1:0]      sel_acc  [NUM_SRC+1];
  stats_t             sel_data;
  stats_t             out_data;
  logic               out_vld;
  logic               can_load;
  logic               accept;
  logic               fwd;

  assign sel_acc[0] = '0;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign req[g]             = stats_in[g].valid;
    assign src_data[g]        = stats_in[g].data;
    assign stats_in[g].ready  = rdy[g];
    assign sel_acc[g+1]       = sel_acc[g] | (grant[g] ? src_data[g] : '0);
  end
  assign sel_data = sel_acc[NUM_SRC];

  assign can_load = !out_vld || stats_out.ready;
  // Reset gating keeps every ready low while Rst_n is asserted.
  assign rdy      = (Rst_n && can_load) ? grant : '0;
  assign accept   = |(req & rdy);
  assign fwd      = accept && stats_fwd(sel_data.addr);

  stats_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .req     (req),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      out_vld  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (fwd) begin
        out_vld  <= 1'b1;
        out_data <= sel_data;
      end else if (stats_out.ready) begin
        out_vld  <= 1'b0;
      end
      if (accept && !fwd && (drop_cnt != 32'hFFFF_FFFF)) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

  assign stats_out.valid = out_vld;
  assign stats_out.sop   = out_vld;
  assign stats_out.eop   = out_vld;
  assign stats_out.data  = out_data;
endmodule

// File: tb/tb_stats_arbiter_avlstrm.sv
// Directed + random bench for stats_arbiter_avlstrm with a FIFO scoreboard.
module tb_stats_arbiter_avlstrm;
  import stats_arbiter_avlstrm_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [3:0]  s_vld;
  logic [3:0]  s_rdy;
  stats_t      s_dat [4];
  logic        o_rdy;
  logic [31:0] drop_cnt;

  always #5 Clk = ~Clk;

  avl_stream_if src_if [4] ();
  avl_stream_if out_if ();

  for (genvar g = 0; g < 4; g++) begin : g_src
    assign src_if[g].valid = s_vld[g];
    assign src_if[g].sop   = s_vld[g];
    assign src_if[g].eop   = s_vld[g];
    assign src_if[g].data  = s_dat[g];
    assign s_rdy[g]        = src_if[g].ready;
  end
  assign out_if.ready = o_rdy;

  stats_arbiter_avlstrm #(.NUM_SRC(4)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .stats_in  (src_if),
    .stats_out (out_if),
    .drop_cnt  (drop_cnt)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  stats_t      src_q [4][$];
  stats_t      exp_q [$];
  int          grant_log [$];
  logic [3:0]  acc = '0;
  int          vld_cycles = 0;
  logic [31:0] exp_reg [16];
  logic [31:0] act_reg [16];
  logic        prev_hold = 1'b0;
  stats_t      prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  function automatic stats_t mk(input logic [7:0] a, input logic [31:0] v);
    stats_t w;
    w.addr = a;
    w.val  = v;
    return w;
  endfunction

  function automatic logic fwd_ok(input logic [7:0] a);
    return (a != REG_NOTUSED) && (a < NUM_REG);
  endfunction

  function automatic logic src_pending();
    return (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) != 0;
  endfunction

  // Advance one cycle, retire accepted words, present each source's queue head.
  task automatic step();
    @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      s_vld[i] = src_q[i].size() > 0;
      s_dat[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((src_pending() || exp_q.size() != 0 || out_if.valid) && n < 500) begin
      step();
      n++;
    end
    chk(tag, 64'(n < 500), 64'd1);
  endtask

  // Monitor: scoreboard push on input handshake, pop/compare on output handshake.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      acc       <= '0;
      prev_hold <= 1'b0;
      exp_q.delete();
    end else begin
      chk("rdy_onehot", 64'($onehot0(s_rdy)), 64'd1);
      chk("framing", 64'({out_if.sop, out_if.eop}), 64'({out_if.valid, out_if.valid}));
      if (out_if.valid && !o_rdy) chk("bp_no_rdy", 64'(s_rdy), 64'd0);
      if (prev_hold) chk("bp_stable", 64'(out_if.data), 64'(prev_data));
      if (out_if.valid) vld_cycles <= vld_cycles + 1;
      if (out_if.valid && o_rdy) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          chk("sb_data", 64'(out_if.data), 64'(exp_q[0]));
          act_reg[out_if.data.addr[3:0]] <= out_if.data.val;
          void'(exp_q.pop_front());
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (s_vld[i] && s_rdy[i]) begin
          grant_log.push_back(i);
          if (fwd_ok(s_dat[i].addr)) begin
            exp_q.push_back(s_dat[i]);
            exp_reg[s_dat[i].addr[3:0]] <= s_dat[i].val;
          end
        end
      end
      acc       <= s_vld & s_rdy;
      prev_hold <= out_if.valid && !o_rdy;
      prev_data <= out_if.data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mism;
    int cnt [4];
    int v0;
    int sent_drops;
    int s;
    logic [7:0] a;

    Rst_n = 1'b0;
    o_rdy = 1'b1;
    s_vld = '0;
    for (int i = 0; i < 4; i++) s_dat[i] = '0;

    // Reset state, with src0 already requesting.
    src_q[0].push_back(mk(8'd3, 32'h11));
    step();
    step();
    @(negedge Clk);
    chk("rst_vld", 64'(out_if.valid), 64'd0);
    chk("rst_sopeop", 64'({out_if.sop, out_if.eop}), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_rdy", 64'(s_rdy), 64'd0);

    // Single source, one-cycle latency.
    step();
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("single_rdy", 64'(s_rdy), 64'b0001);
    step();
    chk("single_vld", 64'(out_if.valid), 64'd1);
    chk("single_dat", 64'(out_if.data), 64'(mk(8'd3, 32'h11)));
    chk("single_sopeop", 64'({out_if.sop, out_if.eop}), 64'b11);
    chk("single_drop", 64'(drop_cnt), 64'd0);
    step();
    chk("single_idle", 64'(out_if.valid), 64'd0);

    // Fairness: four saturated sources, 400 words.
    do_reset();
    grant_log.delete();
    for (int k = 0; k < 100; k++)
      for (int j = 0; j < 4; j++)
        src_q[j].push_back(mk(8'(j + 1), {8'(j), 24'(k)}));
    n = 0;
    do begin
      step();
      n++;
    end while (src_pending() && n < 1000);
    chk("fair_cycles", 64'(n), 64'd401);
    chk("fair_total", 64'(grant_log.size()), 64'd400);
    mism = 0;
    for (int j = 0; j < 4; j++) cnt[j] = 0;
    for (int k = 0; k < grant_log.size(); k++) begin
      if (grant_log[k] != k % 4) mism++;
      if (grant_log[k] >= 0 && grant_log[k] < 4) cnt[grant_log[k]]++;
    end
    chk("fair_order", 64'(mism), 64'd0);
    for (int j = 0; j < 4; j++) chk("fair_share", 64'(cnt[j]), 64'd100);
    drain("fair_drain");

    // Back-pressure: src1 and src2 pending, output stalled for 10 cycles.
    grant_log.delete();
    o_rdy = 1'b0;
    src_q[1].push_back(mk(8'd7, 32'hB1));
    src_q[2].push_back(mk(8'd9, 32'hB2));
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      @(negedge Clk);
      chk("bp_vld", 64'(out_if.valid), 64'd1);
      chk("bp_hold", 64'(out_if.data), 64'(mk(8'd7, 32'hB1)));
      chk("bp_rdys", 64'(s_rdy), 64'd0);
    end
    step();
    o_rdy = 1'b1;
    drain("bp_drain");
    chk("bp_log_n", 64'(grant_log.size()), 64'd2);
    chk("bp_log0", 64'(grant_log[0]), 64'd1);
    chk("bp_log1", 64'(grant_log[1]), 64'd2);

    // Filtering: reserved and out-of-range addresses are consumed and counted.
    v0 = vld_cycles;
    src_q[2].push_back(mk(REG_NOTUSED, 32'hD0));
    src_q[2].push_back(mk(NUM_REG, 32'hD1));
    repeat (4) step();
    chk("filt_drop", 64'(drop_cnt), 64'd2);
    chk("filt_novld", 64'(vld_cycles - v0), 64'd0);
    chk("filt_consumed", 64'(src_q[2].size()), 64'd0);
    src_q[3].push_back(mk(8'd5, 32'h5A5A));
    step();
    step();
    chk("filt_fwd_vld", 64'(out_if.valid), 64'd1);
    chk("filt_fwd_dat", 64'(out_if.data), 64'(mk(8'd5, 32'h5A5A)));
    drain("filt_drain");

    // Reset while a word is held and drop_cnt is 5.
    o_rdy = 1'b0;
    src_q[0].push_back(mk(8'd0, 32'hE0));
    src_q[0].push_back(mk(8'd20, 32'hE1));
    src_q[0].push_back(mk(8'd255, 32'hE2));
    src_q[0].push_back(mk(8'd12, 32'hE3));
    repeat (6) step();
    chk("mid_drop5", 64'(drop_cnt), 64'd5);
    chk("mid_vld", 64'(out_if.valid), 64'd1);
    for (int j = 0; j < 4; j++) src_q[j].push_back(mk(8'(j + 1), 32'hF0 + 32'(j)));
    grant_log.delete();
    Rst_n = 1'b0;
    step();
    @(negedge Clk);
    chk("mid_rst_vld", 64'(out_if.valid), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_rdy", 64'(s_rdy), 64'd0);
    step();
    Rst_n = 1'b1;
    o_rdy = 1'b1;
    drain("mid_drain");
    chk("mid_log_n", 64'(grant_log.size()), 64'd4);
    chk("mid_first", 64'(grant_log[0]), 64'd0);

    // Random traffic: final register image and drop count.
    for (int r = 0; r < 16; r++) begin
      exp_reg[r] = '0;
      act_reg[r] = '0;
    end
    sent_drops = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      o_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) begin
        s = int'($urandom_range(0, 3));
        a = 8'($urandom_range(0, 19));
        src_q[s].push_back(mk(a, $urandom));
        if (!fwd_ok(a)) sent_drops++;
      end
    end
    step();
    o_rdy = 1'b1;
    drain("rnd_drain");
    step();
    chk("rnd_drops", 64'(drop_cnt), 64'(sent_drops));
    for (int r = 0; r < 16; r++) chk("rnd_reg", 64'(act_reg[r]), 64'(exp_reg[r]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
